alu_add_and_cmp_unit: RTL and testbench
=======================================

// Module: alu_add_and_cmp_unit
// PURPOSE
//   Registered integer execute slice for the master ALU. Performs the ADD, AND and CMP
//   operations on two signed 32-bit operands and produces the NZCV flag update.
//   Sits between the operand/flag read stage and the register-file/flag write-back.
//   Conditional-execution gating is decided upstream; this block executes whatever it is issued.
// PARAMETERS
//   WIDTH  32  operand/result width; flag logic references bit WIDTH-1 as sign
// PORTS
//   clk        in   1      single clock, rising-edge
//   reset      in   1      asynchronous, active-high reset
//   in_valid   in   1      issue strobe; op/operands sampled when high
//   op         in   2      00 ADD, 01 AND, 10 CMP, 11 reserved
//   in1        in   WIDTH  operand A (Reg1)
//   in2        in   WIDTH  operand B (Reg2)
//   flag_in    in   4      current flags {N,Z,C,V} = bits [3:0]
//   s          in   1      set-flags enable (ADD/AND only)
//   out_valid  out  1      result/flags valid, one cycle after issue
//   result     out  WIDTH  registered result
//   result_we  out  1      high when result must be written back
//   new_flag   out  4      registered flags {N,Z,C,V}
// BEHAVIOUR
//   - Reset (async, asserted): out_valid=0, result=0, result_we=0, new_flag=4'b0000.
//     Reset has priority over in_valid. An issue cycle coinciding with reset is discarded.
//   - Latency is 1 cycle. An op sampled at edge k is visible after edge k.
//     out_valid is a single-cycle pulse per issue. Back-to-back issue is allowed every cycle.
//   - in_valid=0: out_valid<=0, result_we<=0; result and new_flag hold their values.
//   - Flag bit map: [3]=N sign of result, [2]=Z result==0, [1]=C, [0]=V.
//   - ADD: sum = in1+in2, computed at WIDTH+1 bits; result<=sum[WIDTH-1:0]; result_we<=1.
//       C = carry out of bit WIDTH-1 (unsigned overflow).
//       V = operands have equal signs AND result sign differs from them.
//   - AND: result<=in1&in2; result_we<=1. N and Z are computed from the result.
//       C and V pass through from flag_in.
//   - ADD/AND with s=0: new_flag<=flag_in exactly.
//   - CMP: diff = in1-in2 = in1+~in2+1. Flags always update; s is ignored.
//       N and Z come from diff.
//       C = no-borrow, i.e. 1 iff in1>=in2 unsigned.
//       V = operand signs differ AND diff sign differs from in1.
//       result_we<=0; result holds its previous value.
//   - op=11: out_valid<=1, result_we<=0, result holds, new_flag<=flag_in.
//   - Wrap-around: ADD wraps modulo 2^WIDTH with no saturation.
//       0x7FFFFFFF+1 sets V. 0xFFFFFFFF+1 sets C and Z.
//   - All arithmetic is combinational into a single register stage. No internal state beyond the output registers.
// STRUCTURE
//   - Shared package alu_pkg: op encodings (OP_ADD/OP_AND/OP_CMP/OP_RSVD), flag index
//     constants (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0), WIDTH default.
//   - One sub-module: alu_flag_gen. It is combinational and takes (result, carry, ovf, flag_in, update) and returns {N,Z,C,V}.
//     The top level instantiates it once per op, or once with muxed carry/ovf inputs.
//   - Top level contains the adder/subtractor (shared: B = op==CMP ? ~in2 : in2, cin = op==CMP),
//     the AND array, the op mux and the output registers.
// TESTING
//   1 reset: assert reset mid-stream with in_valid=1 -> outputs are 0 immediately (async).
//     The first valid output appears 1 cycle after the first post-reset issue.
//   2 ADD s=1: 0x7FFFFFFF+0x00000001 -> result=0x80000000, new_flag=1001 (N,V).
//     Then 0xFFFFFFFF+0x00000001 -> result=0, new_flag=0110 (Z,C).
//   3 ADD s=0, flag_in=0101: 5+7 -> result=12, result_we=1, new_flag=0101 unchanged.
//   4 AND s=1, flag_in=0011: 0xF0F0F0F0&0x0F0F0F0F -> result=0, new_flag=0111.
//     Then 0x80000001&0xFFFFFFFF -> result=0x80000001, new_flag=1011.
//   5 CMP s=0: 5 vs 5 -> new_flag=0110, result_we=0, result unchanged.
//     3 vs 5 -> 1000. 0x80000000 vs 1 -> 0011 (C,V).
//   6 throughput/hold: issue ADD, CMP, AND on consecutive cycles, then idle 2 cycles.
//     Outputs match each op 1 cycle later; out_valid drops and values hold while idle.
//     op=11 -> out_valid=1, result_we=0, new_flag=flag_in.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the integer execute slice: op encodings,
// flag bit positions and the default datapath width.
package alu_pkg;

    localparam int WIDTH_DEFAULT = 32;

    // Opcode encodings as issued by the operand/flag read stage.
    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_AND  = 2'b01,
        OP_CMP  = 2'b10,
        OP_RSVD = 2'b11
    } alu_op_e;

    // Bit positions inside the {N,Z,C,V} flag nibble.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Signed-overflow rule for a two-input add: both addends share a
    // sign and the sum's sign differs from it.
    function automatic logic add_overflow(
        input logic sign_a,
        input logic sign_b,
        input logic sign_sum
    );
        return (sign_a == sign_b) && (sign_sum != sign_a);
    endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational NZCV generator. With update set, N/Z come from the
// value, C/V from the supplied carry/overflow; otherwise the incoming
// flags pass through untouched.
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] value,
    input  logic             carry,
    input  logic             ovf,
    input  logic [3:0]       flag_in,
    input  logic             update,
    output logic [3:0]       flag_out
);

    // Select between freshly computed flags and the pass-through set.
    always_comb begin
        flag_out = flag_in;
        if (update) begin
            flag_out[FLAG_N] = value[WIDTH-1];
            flag_out[FLAG_Z] = (value == '0);
            flag_out[FLAG_C] = carry;
            flag_out[FLAG_V] = ovf;
        end
    end

endmodule

// File: rtl/alu_add_and_cmp_unit.sv
// Registered ADD / AND / CMP execute slice with NZCV update.
// One shared adder serves ADD and CMP (CMP adds ~in2 with carry-in 1);
// everything is combinational into a single output register stage.
module alu_add_and_cmp_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [3:0]       flag_in,
    input  logic             s,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             result_we,
    output logic [3:0]       new_flag
);

    logic             is_cmp;
    logic [WIDTH-1:0] operand_b;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] sum;
    logic             add_carry;
    logic             add_ovf;
    logic [WIDTH-1:0] and_vec;

    logic [WIDTH-1:0] value_next;
    logic             carry_sel;
    logic             ovf_sel;
    logic             update_sel;
    logic             result_we_next;
    logic [3:0]       flag_next;

    assign is_cmp = (op == OP_CMP);

    // Shared adder/subtractor: inverting B plus carry-in 1 gives in1-in2,
    // and the carry out then reads as "no borrow".
    assign operand_b = is_cmp ? ~in2 : in2;
    assign sum_ext   = {1'b0, in1} + {1'b0, operand_b} + {{WIDTH{1'b0}}, is_cmp};
    assign sum       = sum_ext[WIDTH-1:0];
    assign add_carry = sum_ext[WIDTH];
    assign add_ovf   = add_overflow(in1[WIDTH-1], operand_b[WIDTH-1], sum[WIDTH-1]);

    // Bitwise AND array, one gate per bit.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_and
            assign and_vec[gi] = in1[gi] & in2[gi];
        end
    endgenerate

    // Op mux: choose the value feeding flags/result and the flag sources.
    always_comb begin
        value_next     = sum;
        carry_sel      = add_carry;
        ovf_sel        = add_ovf;
        update_sel     = 1'b0;
        result_we_next = 1'b0;
        case (op)
            OP_ADD: begin
                value_next     = sum;
                update_sel     = s;
                result_we_next = 1'b1;
            end
            OP_AND: begin
                value_next     = and_vec;
                carry_sel      = flag_in[FLAG_C];
                ovf_sel        = flag_in[FLAG_V];
                update_sel     = s;
                result_we_next = 1'b1;
            end
            OP_CMP: begin
                value_next     = sum;
                update_sel     = 1'b1;
                result_we_next = 1'b0;
            end
            default: begin
                update_sel     = 1'b0;
                result_we_next = 1'b0;
            end
        endcase
    end

    alu_flag_gen #(
        .WIDTH (WIDTH)
    ) u_flag_gen (
        .value    (value_next),
        .carry    (carry_sel),
        .ovf      (ovf_sel),
        .flag_in  (flag_in),
        .update   (update_sel),
        .flag_out (flag_next)
    );

    // Output registers: capture on issue, pulse out_valid, hold data when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            result    <= '0;
            result_we <= 1'b0;
            new_flag  <= 4'b0000;
        end else if (in_valid) begin
            out_valid <= 1'b1;
            result_we <= result_we_next;
            new_flag  <= flag_next;
            if (result_we_next) begin
                result <= value_next;
            end
        end else begin
            out_valid <= 1'b0;
            result_we <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_add_and_cmp_unit.sv
// Directed bench for alu_add_and_cmp_unit with hand-computed vectors.
module tb_alu_add_and_cmp_unit;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [1:0]  op;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [3:0]  flag_in;
    logic        s;
    logic        out_valid;
    logic [31:0] result;
    logic        result_we;
    logic [3:0]  new_flag;

    int checks = 0;
    int errors = 0;

    alu_add_and_cmp_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .op        (op),
        .in1       (in1),
        .in2       (in2),
        .flag_in   (flag_in),
        .s         (s),
        .out_valid (out_valid),
        .result    (result),
        .result_we (result_we),
        .new_flag  (new_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic ev, input logic [31:0] er,
                           input logic ew, input logic [3:0] ef);
        chk({tag, ".valid"}, {31'b0, out_valid}, {31'b0, ev});
        chk({tag, ".result"}, result, er);
        chk({tag, ".we"}, {31'b0, result_we}, {31'b0, ew});
        chk({tag, ".flag"}, {28'b0, new_flag}, {28'b0, ef});
        $display("%s: valid=%b result=%h we=%b flag=%b", tag, out_valid, result, result_we, new_flag);
    endtask

    // Drive one issue at the falling edge, check #1 after the next rising edge.
    task automatic issue(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] f, input logic sf,
                         input logic [31:0] er, input logic ew, input logic [3:0] ef);
        @(negedge clk);
        in_valid = 1'b1; op = o; in1 = a; in2 = b; flag_in = f; s = sf;
        @(posedge clk);
        #1;
        chk_all(tag, 1'b1, er, ew, ef);
    endtask

    task automatic idle(input string tag, input logic [31:0] er, input logic [3:0] ef);
        @(negedge clk);
        in_valid = 1'b0; op = 2'b00; in1 = 32'hDEAD_BEEF; in2 = 32'h1234_5678; flag_in = 4'b1111; s = 1'b1;
        @(posedge clk);
        #1;
        chk_all(tag, 1'b0, er, 1'b0, ef);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; op = 2'b00; in1 = '0; in2 = '0; flag_in = '0; s = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset_init", 1'b0, 32'h0, 1'b0, 4'b0000);
        @(negedge clk);
        reset = 1'b0;

        // Populate outputs, then assert reset mid-stream with an issue pending.
        issue("pre_reset_add", 2'b00, 32'd1, 32'd2, 4'b0000, 1'b1, 32'd3, 1'b1, 4'b0000);
        @(negedge clk);
        in_valid = 1'b1; op = 2'b00; in1 = 32'd10; in2 = 32'd20; flag_in = 4'b1111; s = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk_all("async_reset", 1'b0, 32'h0, 1'b0, 4'b0000);
        @(posedge clk);
        #1;
        chk_all("reset_hold_issue", 1'b0, 32'h0, 1'b0, 4'b0000);
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk_all("post_reset_idle", 1'b0, 32'h0, 1'b0, 4'b0000);

        // ADD with flag update, overflow and carry-wrap corners.
        issue("add_ovf", 2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 4'b0000, 1'b1, 32'h8000_0000, 1'b1, 4'b1001);
        issue("add_wrap", 2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 4'b0000, 1'b1, 32'h0000_0000, 1'b1, 4'b0110);
        // ADD without flag update.
        issue("add_nos", 2'b00, 32'd5, 32'd7, 4'b0101, 1'b0, 32'd12, 1'b1, 4'b0101);
        // AND: N/Z computed, C/V pass through.
        issue("and_zero", 2'b01, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 4'b0011, 1'b1, 32'h0000_0000, 1'b1, 4'b0111);
        issue("and_neg", 2'b01, 32'h8000_0001, 32'hFFFF_FFFF, 4'b0011, 1'b1, 32'h8000_0001, 1'b1, 4'b1011);
        issue("and_nos", 2'b01, 32'h0000_00FF, 32'h0000_0F0F, 4'b1100, 1'b0, 32'h0000_000F, 1'b1, 4'b1100);
        // CMP: flags always update, result holds.
        issue("cmp_eq", 2'b10, 32'd5, 32'd5, 4'b0000, 1'b0, 32'h0000_000F, 1'b0, 4'b0110);
        issue("cmp_lt", 2'b10, 32'd3, 32'd5, 4'b0000, 1'b0, 32'h0000_000F, 1'b0, 4'b1000);
        issue("cmp_ovf", 2'b10, 32'h8000_0000, 32'd1, 4'b0000, 1'b0, 32'h0000_000F, 1'b0, 4'b0011);

        // Back-to-back ADD, CMP, AND then idle hold.
        issue("b2b_add", 2'b00, 32'h10, 32'h20, 4'b0000, 1'b1, 32'h30, 1'b1, 4'b0000);
        issue("b2b_cmp", 2'b10, 32'h30, 32'h30, 4'b0000, 1'b0, 32'h30, 1'b0, 4'b0110);
        issue("b2b_and", 2'b01, 32'h0000_FF00, 32'h0000_0FF0, 4'b1110, 1'b1, 32'h0000_0F00, 1'b1, 4'b0010);
        idle("idle1", 32'h0000_0F00, 4'b0010);
        idle("idle2", 32'h0000_0F00, 4'b0010);

        // Reserved op: valid pulse, no write, flags pass through.
        issue("rsvd", 2'b11, 32'h1111_1111, 32'h2222_2222, 4'b1010, 1'b1, 32'h0000_0F00, 1'b0, 4'b1010);
        idle("idle3", 32'h0000_0F00, 4'b1010);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
